// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch stage: instruction field
// positions, the default reset PC and the buffered fetch-entry layout.
package ifetch_pkg;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low two bits are discarded.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO with flush, used both for the instruction buffer
// and for the in-flight request PC queue. Push and pop may coincide in the
// same cycle, including when the FIFO is full or empty.
module ifetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               data_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               data_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot, so a push into a full FIFO is accepted alongside it.
    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    end

    // Storage, pointers and occupancy; flush empties without touching storage.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Head entry is read combinationally from storage.
    always_comb begin
        data_o  = mem_q[rd_ptr_q];
        count_o = count_q;
    end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues word reads over a
// req/gnt + rvalid handshake, buffers returned words in order and presents
// them to decode. Redirects flush buffered data and drop in-flight replies.
// Optional macro IFETCH_PERF_EN adds saturating fetch/stall counters.
module ifetch_stage
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [5:0]  id_op,
    output logic [5:0]  id_func
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]  pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW:0]  occ;
    logic         grant;
    logic         resp_keep;
    logic         pop_id;
    logic [CW-1:0] buf_count;
    logic [CW-1:0] pq_count;
    logic [31:0]  pq_head;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    // Issue rule, handshake qualifiers and the entry pushed on a kept reply.
    always_comb begin
        occ              = {1'b0, out_q} + {1'b0, buf_count};
        imem_req         = rst_n && !redirect_valid && (occ < (CW+1)'(DEPTH));
        imem_addr        = pc_q;
        grant            = imem_req && imem_gnt;
        resp_keep        = imem_rvalid && (drop_q == '0);
        id_valid         = rst_n && (buf_count != '0);
        pop_id           = id_valid && id_ready;
        push_entry.instr = imem_rdata;
        push_entry.pc    = pq_head;
    end

    // Next PC, outstanding and drop counts; a redirect overrides everything
    // and marks every reply still owed (after this cycle) as stale.
    always_comb begin
        pc_d   = pc_q;
        out_d  = out_q;
        drop_d = drop_q;
        if (grant) begin
            pc_d = pc_q + 32'd4;
        end
        case ({grant, imem_rvalid})
            2'b10:   out_d = out_q + CW'(1);
            2'b01:   out_d = out_q - CW'(1);
            default: out_d = out_q;
        endcase
        if (imem_rvalid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
        if (redirect_valid) begin
            pc_d   = align_word(redirect_pc);
            drop_d = out_d;
        end
    end

    // Fetch control state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            out_q  <= out_d;
            drop_q <= drop_d;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_pc_queue (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (redirect_valid),
        .push_i  (grant),
        .data_i  (pc_q),
        .pop_i   (resp_keep),
        .data_o  (pq_head),
        .count_o (pq_count)
    );

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_instr_buf (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (redirect_valid),
        .push_i  (resp_keep && !redirect_valid),
        .data_i  (push_entry),
        .pop_i   (pop_id),
        .data_o  (head_entry),
        .count_o (buf_count)
    );

    // Decode-facing fields; held at zero while reset is asserted.
    always_comb begin
        id_instr = rst_n ? head_entry.instr : '0;
        id_pc    = rst_n ? head_entry.pc    : '0;
        id_op    = id_instr[OP_MSB:OP_LSB];
        id_func  = id_instr[FUNC_MSB:FUNC_LSB];
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;

    // Saturating performance counters; redirects do not clear them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (pop_id && !redirect_valid && (perf_fetch_q != '1)) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (id_ready && !id_valid && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

    // A reply with nothing outstanding, or a kept reply with no tracked PC,
    // means the memory side broke the in-order handshake.
    a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> (out_q != '0));
    a_keep_has_pc: assert property (@(posedge clk) disable iff (!rst_n)
        resp_keep |-> (pq_count != '0));

endmodule

// File: tb/tb_ifetch_stage.sv
module tb_ifetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [5:0]  id_op;
    logic [5:0]  id_func;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] I0   = 32'h8C22_0004;
    localparam logic [31:0] I1   = 32'h0043_0820;
    localparam logic [31:0] I2   = 32'hDEAD_BEEF;
    localparam logic [31:0] I3   = 32'h1234_5678;
    localparam logic [31:0] I100 = 32'hA5A5_0001;
    localparam logic [31:0] I200 = 32'h0BAD_F00D;
    localparam logic [31:0] I400 = 32'hCAFE_0400;
    localparam logic [31:0] IW   = 32'h7777_FFFC;
    localparam logic [31:0] IZ   = 32'h4444_0000;
    localparam logic [31:0] ST   = 32'hFFFF_0BAD;

    ifetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_op          (id_op),
        .id_func        (id_func)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic gnt, input logic rv, input logic [31:0] rd,
                         input logic redir, input logic [31:0] rpc, input logic rdy);
        imem_gnt       = gnt;
        imem_rvalid    = rv;
        imem_rdata     = rd;
        redirect_valid = redir;
        redirect_pc    = rpc;
        id_ready       = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 32'h0, 0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_idv", 32'(id_valid), 32'd0);
        tick();
        drive(0, 0, 32'h0, 0, 32'h0, 0);
        tick();
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_pc", id_pc, 32'h0);

        // Streaming: grant immediately, reply one cycle later, decode ready.
        rst_n = 1'b1;
        drive(1, 0, 32'h0, 0, 32'h0, 1);
        chk("A_req", 32'(imem_req), 32'd1);
        chk("A_addr", imem_addr, 32'h0);
        tick();
        drive(1, 1, I0, 0, 32'h0, 1);
        chk("B_addr", imem_addr, 32'h4);
        chk("B_idv", 32'(id_valid), 32'd0);
        tick();
        drive(1, 1, I1, 0, 32'h0, 1);
        chk("C_idv", 32'(id_valid), 32'd1);
        chk("C_pc", id_pc, 32'h0);
        chk("C_instr", id_instr, I0);
        chk("C_op", 32'(id_op), 32'h23);
        chk("C_func", 32'(id_func), 32'h04);
        chk("C_req", 32'(imem_req), 32'd0);
        tick();
        drive(1, 0, 32'h0, 0, 32'h0, 1);
        chk("D_pc", id_pc, 32'h4);
        chk("D_instr", id_instr, I1);
        chk("D_func", 32'(id_func), 32'h20);
        chk("D_addr", imem_addr, 32'h8);
        tick();

        // Decode stall: buffer fills, fetch stops, nothing lost.
        drive(1, 1, I2, 0, 32'h0, 0);
        chk("E_addr", imem_addr, 32'hC);
        chk("E_idv", 32'(id_valid), 32'd0);
        tick();
        drive(1, 1, I3, 0, 32'h0, 0);
        chk("F_req", 32'(imem_req), 32'd0);
        chk("F_pc", id_pc, 32'h8);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 32'h0, 0, 32'h0, 0);
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_pc", id_pc, 32'h8);
            tick();
        end
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        chk("H_instr", id_instr, I2);
        chk("H_op", 32'(id_op), 32'h37);
        chk("H_req", 32'(imem_req), 32'd0);
        tick();
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        chk("I_pc", id_pc, 32'hC);
        chk("I_instr", id_instr, I3);
        chk("I_addr", imem_addr, 32'h10);
        tick();
        drive(1, 0, 32'h0, 0, 32'h0, 1);
        chk("J_idv", 32'(id_valid), 32'd0);
        chk("J_addr_hold", imem_addr, 32'h10);
        tick();
        drive(1, 0, 32'h0, 0, 32'h0, 1);
        chk("K_addr", imem_addr, 32'h14);
        tick();

        // Redirect with two fetches outstanding: both replies dropped.
        drive(1, 0, 32'h0, 1, 32'h100, 1);
        chk("L_req_forced0", 32'(imem_req), 32'd0);
        tick();
        drive(0, 1, ST, 0, 32'h0, 1);
        chk("M_req", 32'(imem_req), 32'd0);
        tick();
        drive(1, 1, ST, 0, 32'h0, 1);
        chk("N_addr", imem_addr, 32'h100);
        chk("N_idv", 32'(id_valid), 32'd0);
        tick();
        drive(0, 1, I100, 0, 32'h0, 0);
        chk("O_idv", 32'(id_valid), 32'd0);
        chk("O_addr", imem_addr, 32'h104);
        tick();
        drive(1, 0, 32'h0, 0, 32'h0, 0);
        chk("P_pc", id_pc, 32'h100);
        chk("P_instr", id_instr, I100);
        tick();

        // Redirect coinciding with a reply and a pop; unaligned target.
        drive(0, 1, ST, 1, 32'h203, 1);
        chk("Q_req", 32'(imem_req), 32'd0);
        tick();
        drive(1, 0, 32'h0, 0, 32'h0, 1);
        chk("R_idv", 32'(id_valid), 32'd0);
        chk("R_addr", imem_addr, 32'h200);
        tick();
        drive(0, 1, I200, 0, 32'h0, 1);
        chk("S_idv", 32'(id_valid), 32'd0);
        tick();
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        chk("T_pc", id_pc, 32'h200);
        chk("T_instr", id_instr, I200);
        tick();

        // Back-to-back redirects with drop accumulation.
        drive(1, 0, 32'h0, 0, 32'h0, 1);
        chk("U_addr", imem_addr, 32'h204);
        tick();
        drive(1, 0, 32'h0, 0, 32'h0, 1);
        chk("V_addr", imem_addr, 32'h208);
        tick();
        drive(0, 1, ST, 1, 32'h300, 1);
        tick();
        drive(0, 0, 32'h0, 1, 32'h400, 1);
        tick();
        drive(1, 1, ST, 0, 32'h0, 1);
        chk("Y_addr", imem_addr, 32'h400);
        tick();
        drive(0, 1, I400, 0, 32'h0, 0);
        chk("Z_idv", 32'(id_valid), 32'd0);
        tick();
        drive(0, 0, 32'h0, 0, 32'h0, 0);
        chk("Z2_pc", id_pc, 32'h400);
        chk("Z2_instr", id_instr, I400);
        tick();

        // PC wrap at the top of the address space.
        drive(0, 0, 32'h0, 1, 32'hFFFF_FFFC, 1);
        tick();
        drive(1, 0, 32'h0, 0, 32'h0, 0);
        chk("W_addr_top", imem_addr, 32'hFFFF_FFFC);
        chk("W_idv", 32'(id_valid), 32'd0);
        tick();
        drive(1, 1, IW, 0, 32'h0, 0);
        chk("W_addr_wrap", imem_addr, 32'h0);
        tick();
        drive(1, 1, IZ, 0, 32'h0, 0);
        chk("W_pc", id_pc, 32'hFFFF_FFFC);
        chk("W_instr", id_instr, IW);
        chk("W_req_full", 32'(imem_req), 32'd0);
        tick();

        // Reset with a full buffer, then restart from RESET_PC.
        rst_n = 1'b0;
        drive(1, 0, 32'h0, 0, 32'h0, 1);
        chk("X_req_in_rst", 32'(imem_req), 32'd0);
        chk("X_idv_in_rst", 32'(id_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        chk("X_idv_after", 32'(id_valid), 32'd0);
        chk("X_req_after", 32'(imem_req), 32'd1);
        chk("X_addr_after", imem_addr, 32'h0);
        chk("X_instr_after", id_instr, 32'h0);
        chk("X_pc_after", id_pc, 32'h0);
`ifdef IFETCH_PERF_EN
        chk("X_perf_fetch", perf_fetch_cnt, 32'h0);
        chk("X_perf_stall", perf_stall_cnt, 32'h0);
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
